// File: rtl/plot_fb_writer.sv
// Plot-stream sink: clips plots, queues {addr, colour} in a small FIFO and
// drains them into a stallable framebuffer write port; also runs full-screen clears.
//
// state | meaning
// IDLE  | drain FIFO into the write port; accept clear requests once drained
// CLEAR | write clear_colour to every pixel in address order
// CDONE | clear finished, hold clear_done until clear_start drops
module plot_fb_writer #(
  parameter int DEPTH = 8,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               vga_x,
  input  logic [6:0]               vga_y,
  input  logic [2:0]               vga_colour,
  input  logic                     vga_plot,
  input  logic                     clear_start,
  input  logic [2:0]               clear_colour,
  output logic                     clear_done,
  output logic                     fb_we,
  output logic [14:0]              fb_addr,
  output logic [2:0]               fb_wdata,
  input  logic                     fb_wait,
  output logic                     busy,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int NPIX = SCR_W * SCR_H;
  localparam logic [14:0] LAST_ADDR = 15'(NPIX - 1);
  localparam logic [7:0] X_LIM = 8'(SCR_W);
  localparam logic [6:0] Y_LIM = 7'(SCR_H);
  localparam logic [14:0] ROW_W = 15'(SCR_W);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR, CDONE} state_t;

  state_t        state;
  logic [14:0]   mem_addr [DEPTH];
  logic [2:0]    mem_col  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [14:0]   clr_cnt;

  logic          push_req;
  logic          fifo_empty;
  logic          fifo_full;
  logic          out_free;
  logic          out_accept;
  logic          pop;
  logic          push;
  logic          overflow_set;
  logic [14:0]   plot_addr;

  assign push_req     = vga_plot && (vga_x < X_LIM) && (vga_y < Y_LIM);
  assign plot_addr    = 15'(vga_y) * ROW_W + 15'(vga_x);
  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == FULL_CNT);
  assign out_free     = !fb_we || !fb_wait;
  assign out_accept   = fb_we && !fb_wait;
  assign pop          = (state == IDLE) && out_free && !fifo_empty;
  // A pop on the same edge frees a slot, so a full FIFO can still take the push.
  assign push         = push_req && (!fifo_full || pop);
  assign overflow_set = push_req && fifo_full && !pop;

  assign busy       = !fifo_empty || fb_we || (state == CLEAR);
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= plot_addr;
      mem_col[wr_ptr]  <= vga_colour;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      clear_done <= 1'b0;
      overflow   <= 1'b0;
      clr_cnt    <= '0;
    end else begin
      if (overflow_set)
        overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (pop) begin
            fb_we    <= 1'b1;
            fb_addr  <= mem_addr[rd_ptr];
            fb_wdata <= mem_col[rd_ptr];
          end else if (out_free) begin
            fb_we <= 1'b0;
          end
          if (clear_start && fifo_empty && !fb_we) begin
            state    <= CLEAR;
            clr_cnt  <= '0;
            overflow <= 1'b0;
          end
        end
        CLEAR: begin
          // clr_cnt is the next pixel to present; it moves only when the register frees up.
          if (out_free) begin
            if (out_accept && fb_addr == LAST_ADDR) begin
              fb_we      <= 1'b0;
              clear_done <= 1'b1;
              state      <= CDONE;
            end else begin
              fb_we    <= 1'b1;
              fb_addr  <= clr_cnt;
              fb_wdata <= clear_colour;
              clr_cnt  <= clr_cnt + 1'b1;
            end
          end
        end
        CDONE: begin
          fb_we <= 1'b0;
          if (!clear_start) begin
            clear_done <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/plot_fb_writer.md
Name: plot_fb_writer

Overview:
- Receiving end of the plot stream produced by the circle/shape drawers: vga_x, vga_y, vga_colour, vga_plot.
- Clips each plot, computes the linear framebuffer address, and buffers writes in a small FIFO.
- Drains the FIFO into a single-port 160x120x3 framebuffer write port that can stall.
- Also performs a full-screen clear, using the same start/finished level handshake the drawers use.

Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- SCR_W, 160: screen width in pixels.
- SCR_H, 120: screen height in pixels.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- vga_x  in  8  plot x coordinate
- vga_y  in  7  plot y coordinate
- vga_colour  in  3  plot colour
- vga_plot  in  1  plot valid, sampled every rising edge; there is no backpressure to the source
- clear_start  in  1  level request for a full-screen clear
- clear_colour  in  3  fill colour for the clear
- clear_done  out  1  clear finished; held high until clear_start drops
- fb_we  out  1  framebuffer write request
- fb_addr  out  15  write address, y*SCR_W + x
- fb_wdata  out  3  write colour
- fb_wait  in  1  framebuffer stall; the write is not accepted this cycle
- busy  out  1  high when the FIFO is non-empty, the output is valid, or a clear is in progress
- overflow  out  1  sticky: a plot was dropped because the FIFO was full
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: on any clk edge with rst_n=0, every output goes to 0, the FIFO is emptied, the clear counter is zeroed, and state becomes IDLE. Reset mid-clear or mid-drain discards all pending writes.
- Input stage:
  - At each edge with vga_plot=1, vga_x<SCR_W and vga_y<SCR_H, push {addr, colour} into the FIFO.
  - addr = (vga_y<<7)+(vga_y<<5)+vga_x, computed at 15 bits.
  - Off-screen plots are silently dropped and do not set overflow.
- FIFO full:
  - A valid push is dropped and overflow is set.
  - If a pop occurs on the same edge, the push succeeds.
  - overflow clears only on reset or on the IDLE->CLEAR transition.
- Output register (fb_we, fb_addr, fb_wdata):
  - A write is accepted on an edge where fb_we=1 and fb_wait=0.
  - While fb_wait=1, fb_we, fb_addr and fb_wdata hold unchanged.
  - The register reloads when it is empty or its write is being accepted.
- Latency: a plot sampled at edge E into an empty FIFO is loaded into the output register at edge E+1, so fb_we=1 in the cycle after E+1. Sustained throughput is 1 write per cycle while fb_wait=0.
- State machine:
  - IDLE:
    - Pop the FIFO head into the output register when allowed.
    - Go to CLEAR when clear_start=1, the FIFO is empty and no write is pending.
    - A clear request with a pending write waits for the drain to finish.
  - CLEAR:
    - Output register loads addr = clear counter (0..SCR_W*SCR_H-1) with clear_colour. Clear writes take priority; the FIFO is not popped.
    - The counter advances on each accepted write.
    - Plots keep being pushed; overflow rules still apply.
    - Go to CDONE on acceptance of address 19199.
  - CDONE:
    - clear_done=1 and fb_we=0.
    - The FIFO is not drained.
    - Return to IDLE when clear_start=0; clear_done returns to 0 on the same edge.
- clear_colour is sampled every write, so it must be held stable through the clear.
- clear_start falling mid-CLEAR does not abort the clear; the block still passes through CDONE, leaves it on the next edge, and clear_done pulses for 1 cycle.
- fifo_count reflects pushes and pops on the same edge, so simultaneous push and pop leaves it unchanged.

Test Plan:
- After reset: one plot (x=10, y=5, colour=3), fb_wait=0 -> fb_we=1 for exactly one cycle, two edges later, with fb_addr=810 and fb_wdata=3. busy falls the following cycle.
- Off-screen plots (x=160, y=0) and (x=0, y=120), plus vga_plot=0 with any coords -> no fb_we, fifo_count stays 0, overflow=0.
- fb_wait held at 1 while 12 consecutive plots arrive -> at most DEPTH+1 writes are retained and overflow=1. After fb_wait=0 the retained writes emerge in order, with addr/data stable through every stalled cycle.
- clear_start=1, clear_colour=5, fb_wait=0:
  - Addresses 0..19199 are written with 5 in 19200 consecutive accepted writes.
  - clear_done=1 until clear_start=0, then IDLE.
  - A random fb_wait pattern still yields exactly 19200 accepted writes with no gaps or repeats.
- Plots injected during CLEAR (3 points) -> written after CDONE->IDLE, in order, with the correct addresses.
- rst_n=0 asserted at address 1000 mid-clear and again with 4 FIFO entries pending -> the next cycle shows fb_we=0, fifo_count=0, clear_done=0, overflow=0, and no further writes.
